// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port, with a pending-write scoreboard
// that flags read-after-write hazards on the two read addresses.
module regfile_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 claim_valid,
    input  logic [AW-1:0]        claim_addr,
    input  logic [AW-1:0]        rr1_in,
    input  logic [AW-1:0]        rr2_in,
    output logic                 stall_out,
    output logic [(1<<AW)-1:0]   busy_out,
    output logic                 regwrite,
    output logic [AW-1:0]        wr_in,
    output logic [DW-1:0]        write_data_in
);

    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NREG = 1 << AW;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_idx, idx;
    logic            gnt_found, gnt_valid;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_data;
    logic [AW-1:0]   addr_arr [NREQ];
    logic [DW-1:0]   data_arr [NREQ];
    logic [NREG-1:0] busy_q, busy_d;
    logic            regwrite_q;
    logic [AW-1:0]   wr_q;
    logic [DW-1:0]   wdata_q;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_arr[i] = req_addr[i*AW +: AW];
            data_arr[i] = req_data[i*DW +: DW];
        end
    end

    // Walk the requesters starting at ptr with wrap-around; first valid one wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        idx       = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
            idx = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end

    // No grant may be visible while reset is held.
    assign gnt_valid = gnt_found && reset;
    assign gnt_addr  = addr_arr[gnt_idx];
    assign gnt_data  = data_arr[gnt_idx];

    always_comb begin
        req_ready = '0;
        if (gnt_valid) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid) begin
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // A same-cycle claim beats the clear: it belongs to a younger instruction.
    always_comb begin
        busy_d = busy_q;
        if (gnt_valid) begin
            busy_d[gnt_addr] = 1'b0;
        end
        if (claim_valid) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            busy_q     <= '0;
            regwrite_q <= 1'b0;
            wr_q       <= '0;
            wdata_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            regwrite_q <= gnt_valid && (gnt_addr != '0);
            if (gnt_valid) begin
                wr_q    <= gnt_addr;
                wdata_q <= gnt_data;
            end
        end
    end

    assign stall_out     = busy_q[rr1_in] | busy_q[rr2_in];
    assign busy_out      = busy_q;
    assign regwrite      = regwrite_q;
    assign wr_in         = wr_q;
    assign write_data_in = wdata_q;

endmodule
